// File: rtl/hnoc_pkg.sv
// Shared constants, flit type and routing-mode enum for the two-level HNOC.
package hnoc_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int NUM_PE       = 16;
    localparam int ADDR_WIDTH   = $clog2(NUM_PE);
    localparam int CLUSTER_SIZE = 4;
    localparam int NUM_CLUSTERS = NUM_PE / CLUSTER_SIZE;
    localparam int LOCAL_BITS   = $clog2(CLUSTER_SIZE);
    localparam int CLUSTER_BITS = ADDR_WIDTH - LOCAL_BITS;
    localparam int FLIT_WIDTH   = DATA_WIDTH + ADDR_WIDTH;

    localparam int DEST_MSB    = FLIT_WIDTH - 1;
    localparam int DEST_LSB    = DATA_WIDTH;
    localparam int PAYLOAD_MSB = DATA_WIDTH - 1;
    localparam int PAYLOAD_LSB = 0;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    typedef enum logic {
        ROUTE_LEAF,
        ROUTE_ROOT
    } route_mode_e;

    function automatic logic [ADDR_WIDTH-1:0] flit_dest(flit_t f);
        return f[DEST_MSB:DEST_LSB];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] flit_payload(flit_t f);
        return f[PAYLOAD_MSB:PAYLOAD_LSB];
    endfunction

endpackage

// File: rtl/hnoc_if.sv
// PE-facing bundle of all 16 ingress/egress valid-ready channels.
interface hnoc_if;
    import hnoc_pkg::*;

    flit_t i_pe_data       [NUM_PE];
    logic  i_pe_data_valid [NUM_PE];
    logic  o_pe_data_ready [NUM_PE];
    flit_t o_pe_data       [NUM_PE];
    logic  o_pe_data_valid [NUM_PE];
    logic  i_pe_data_ready [NUM_PE];

    modport slave (
        input  i_pe_data, i_pe_data_valid, i_pe_data_ready,
        output o_pe_data_ready, o_pe_data, o_pe_data_valid
    );

    modport master (
        output i_pe_data, i_pe_data_valid, i_pe_data_ready,
        input  o_pe_data_ready, o_pe_data, o_pe_data_valid
    );

endinterface

// File: rtl/hnoc_switch.sv
// N-port switch: 2-entry FIFO per input, 1-entry register per output, round-robin per output.
// Leaf mode routes local destinations to ports 0..3 and everything else to the uplink port.
module hnoc_switch
    import hnoc_pkg::*;
#(
    parameter int          NUM_PORTS  = CLUSTER_SIZE + 1,
    parameter route_mode_e MODE       = ROUTE_LEAF,
    parameter int          CLUSTER_ID = 0,
    parameter int          FLIT_W     = FLIT_WIDTH,
    parameter int          DEST_LO    = DEST_LSB
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [FLIT_W-1:0] in_data   [NUM_PORTS],
    input  logic              in_valid  [NUM_PORTS],
    output logic              in_ready  [NUM_PORTS],
    output logic [FLIT_W-1:0] out_data  [NUM_PORTS],
    output logic              out_valid [NUM_PORTS],
    input  logic              out_ready [NUM_PORTS]
);

    localparam int PW = $clog2(NUM_PORTS);

    logic [FLIT_W-1:0] fifo_mem  [NUM_PORTS][2];
    logic              fifo_wr   [NUM_PORTS];
    logic              fifo_rd   [NUM_PORTS];
    logic [1:0]        fifo_cnt  [NUM_PORTS];
    logic [FLIT_W-1:0] head      [NUM_PORTS];
    logic [PW-1:0]     route     [NUM_PORTS];
    logic              req       [NUM_PORTS];
    logic              push      [NUM_PORTS];
    logic              pop       [NUM_PORTS];
    logic              out_free  [NUM_PORTS];
    logic [PW-1:0]     rr_ptr    [NUM_PORTS];
    logic              gnt_valid [NUM_PORTS];
    logic [PW-1:0]     gnt_idx   [NUM_PORTS];
    int                cand;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            head[i]     = fifo_mem[i][fifo_rd[i]];
            req[i]      = (fifo_cnt[i] != 2'd0);
            in_ready[i] = (fifo_cnt[i] != 2'd2) && !i_reset;
            push[i]     = in_valid[i] && in_ready[i];
            out_free[i] = !out_valid[i] || out_ready[i];
            if (MODE == ROUTE_ROOT) begin
                route[i] = PW'(head[i][DEST_LO+LOCAL_BITS +: CLUSTER_BITS]);
            end else if (head[i][DEST_LO+LOCAL_BITS +: CLUSTER_BITS] == CLUSTER_BITS'(CLUSTER_ID)) begin
                route[i] = PW'(head[i][DEST_LO +: LOCAL_BITS]);
            end else begin
                route[i] = PW'(CLUSTER_SIZE);
            end
        end
    end

    // Each head targets exactly one output, so an input is never granted twice.
    always_comb begin
        cand = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pop[i]       = 1'b0;
            gnt_valid[i] = 1'b0;
            gnt_idx[i]   = '0;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                cand = int'(rr_ptr[o]) + k;
                if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
                if (out_free[o] && !gnt_valid[o] && req[cand] && route[cand] == PW'(o)) begin
                    gnt_valid[o] = 1'b1;
                    gnt_idx[o]   = PW'(cand);
                end
            end
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (gnt_valid[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                fifo_mem[i][0] <= '0;
                fifo_mem[i][1] <= '0;
                fifo_wr[i]     <= 1'b0;
                fifo_rd[i]     <= 1'b0;
                fifo_cnt[i]    <= 2'd0;
                out_data[i]    <= '0;
                out_valid[i]   <= 1'b0;
                rr_ptr[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (push[i]) begin
                    fifo_mem[i][fifo_wr[i]] <= in_data[i];
                    fifo_wr[i]              <= ~fifo_wr[i];
                end
                if (pop[i]) fifo_rd[i] <= ~fifo_rd[i];
                case ({push[i], pop[i]})
                    2'b10:   fifo_cnt[i] <= fifo_cnt[i] + 2'd1;
                    2'b01:   fifo_cnt[i] <= fifo_cnt[i] - 2'd1;
                    default: fifo_cnt[i] <= fifo_cnt[i];
                endcase
            end
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (gnt_valid[o]) begin
                    out_data[o]  <= head[gnt_idx[o]];
                    out_valid[o] <= 1'b1;
                    rr_ptr[o]    <= (gnt_idx[o] == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx[o] + 1'b1;
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/hnoc.sv
// Two-level NoC top: four 5-port leaf switches joined by one 4-port root switch.
// Optional HNOC_PKT_COUNT_EN adds o_pkt_count, a wrapping count of all PE output transfers.
module hnoc
    import hnoc_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int numPE     = NUM_PE,
    parameter int AddrWidth = $clog2(numPE)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    hnoc_if.slave       pe
`ifdef HNOC_PKT_COUNT_EN
    ,
    output logic [31:0] o_pkt_count
`endif
);

    localparam int FW = DataWidth + AddrWidth;
    localparam int NC = numPE / CLUSTER_SIZE;
    localparam int LP = CLUSTER_SIZE + 1;

    logic [FW-1:0] leaf_in_data   [NC][LP];
    logic          leaf_in_valid  [NC][LP];
    logic          leaf_in_ready  [NC][LP];
    logic [FW-1:0] leaf_out_data  [NC][LP];
    logic          leaf_out_valid [NC][LP];
    logic          leaf_out_ready [NC][LP];
    logic [FW-1:0] root_in_data   [NC];
    logic          root_in_valid  [NC];
    logic          root_in_ready  [NC];
    logic [FW-1:0] root_out_data  [NC];
    logic          root_out_valid [NC];
    logic          root_out_ready [NC];

    for (genvar c = 0; c < NC; c++) begin : g_leaf
        for (genvar j = 0; j < CLUSTER_SIZE; j++) begin : g_port
            localparam int P = c * CLUSTER_SIZE + j;
            assign leaf_in_data[c][j]   = pe.i_pe_data[P];
            assign leaf_in_valid[c][j]  = pe.i_pe_data_valid[P];
            assign pe.o_pe_data_ready[P] = leaf_in_ready[c][j];
            assign pe.o_pe_data[P]       = leaf_out_data[c][j];
            assign pe.o_pe_data_valid[P] = leaf_out_valid[c][j];
            assign leaf_out_ready[c][j] = pe.i_pe_data_ready[P];
        end

        // The last leaf port is the uplink to root port c.
        assign leaf_in_data[c][CLUSTER_SIZE]   = root_out_data[c];
        assign leaf_in_valid[c][CLUSTER_SIZE]  = root_out_valid[c];
        assign root_out_ready[c]               = leaf_in_ready[c][CLUSTER_SIZE];
        assign root_in_data[c]                 = leaf_out_data[c][CLUSTER_SIZE];
        assign root_in_valid[c]                = leaf_out_valid[c][CLUSTER_SIZE];
        assign leaf_out_ready[c][CLUSTER_SIZE] = root_in_ready[c];

        hnoc_switch #(
            .NUM_PORTS  (LP),
            .MODE       (ROUTE_LEAF),
            .CLUSTER_ID (c),
            .FLIT_W     (FW),
            .DEST_LO    (DataWidth)
        ) u_leaf (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .in_data   (leaf_in_data[c]),
            .in_valid  (leaf_in_valid[c]),
            .in_ready  (leaf_in_ready[c]),
            .out_data  (leaf_out_data[c]),
            .out_valid (leaf_out_valid[c]),
            .out_ready (leaf_out_ready[c])
        );
    end

    hnoc_switch #(
        .NUM_PORTS  (NC),
        .MODE       (ROUTE_ROOT),
        .CLUSTER_ID (0),
        .FLIT_W     (FW),
        .DEST_LO    (DataWidth)
    ) u_root (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .in_data   (root_in_data),
        .in_valid  (root_in_valid),
        .in_ready  (root_in_ready),
        .out_data  (root_out_data),
        .out_valid (root_out_valid),
        .out_ready (root_out_ready)
    );

`ifdef HNOC_PKT_COUNT_EN
    localparam int SW = $clog2(numPE + 1);
    logic [SW-1:0] xfer_sum;

    always_comb begin
        xfer_sum = '0;
        for (int p = 0; p < numPE; p++) begin
            xfer_sum = xfer_sum + SW'(pe.o_pe_data_valid[p] & pe.i_pe_data_ready[p]);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) o_pkt_count <= '0;
        else         o_pkt_count <= o_pkt_count + 32'(xfer_sum);
    end
`endif

endmodule

// File: tb/tb_hnoc.sv
// Scoreboard bench for hnoc: per source/destination queues filled on input acceptance.
module tb_hnoc;
    import hnoc_pkg::*;

    typedef struct {
        flit_t f;
        int    acc_edge;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hnoc_if bus();
`ifdef HNOC_PKT_COUNT_EN
    logic [31:0] pkt_count;
`endif

    hnoc dut (
        .i_clk   (clk),
        .i_reset (rst),
        .pe      (bus)
`ifdef HNOC_PKT_COUNT_EN
        ,
        .o_pkt_count (pkt_count)
`endif
    );

    sb_t   sb [NUM_PE*NUM_PE][$];
    flit_t tx_q [NUM_PE][$];
    int    deliv_src [NUM_PE][$];
    int    deliv_cyc [NUM_PE][$];
    int    del_count [NUM_PE];
    int    acc_count [NUM_PE];
    int    last_lat  [NUM_PE];
    logic  hold_pend [NUM_PE];
    flit_t hold_data [NUM_PE];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    deliv_total = 0;
    int    xfers = 0;

    function automatic flit_t mk(int dst, logic [31:0] pl);
        return {ADDR_WIDTH'(dst), pl};
    endfunction

    function automatic logic [NUM_PE-1:0] valid_vec();
        logic [NUM_PE-1:0] v;
        for (int p = 0; p < NUM_PE; p++) v[p] = bus.o_pe_data_valid[p];
        return v;
    endfunction

    function automatic logic [NUM_PE-1:0] ready_vec();
        logic [NUM_PE-1:0] v;
        for (int p = 0; p < NUM_PE; p++) v[p] = bus.o_pe_data_ready[p];
        return v;
    endfunction

    // Samples at the falling edge, then drives fresh inputs 1 time unit after the rising edge.
    task automatic step();
        sb_t e;
        int  k;
        int  dst;
        bit  found;
        @(negedge clk);
        if (!rst) begin
            for (int d = 0; d < NUM_PE; d++) begin
                if (bus.o_pe_data_valid[d]) begin
                    if (hold_pend[d]) begin
                        vectors++;
                        if (bus.o_pe_data[d] !== hold_data[d]) begin
                            miscompares++;
                            $display("FAIL hold_stable port %0d: got %h want %h", d, bus.o_pe_data[d], hold_data[d]);
                        end
                    end
                    if (bus.i_pe_data_ready[d]) begin
                        vectors++;
                        found = 1'b0;
                        for (int s = 0; s < NUM_PE; s++) begin
                            k = s * NUM_PE + d;
                            if (!found && sb[k].size() > 0 && sb[k][0].f === bus.o_pe_data[d]) begin
                                found = 1'b1;
                                last_lat[d] = cyc - sb[k][0].acc_edge;
                                deliv_src[d].push_back(s);
                                deliv_cyc[d].push_back(cyc);
                                void'(sb[k].pop_front());
                            end
                        end
                        if (!found) begin
                            miscompares++;
                            $display("FAIL sb_match port %0d: got %h want a pending in-order flit", d, bus.o_pe_data[d]);
                        end
                        del_count[d]++;
                        deliv_total++;
                        xfers++;
                        hold_pend[d] = 1'b0;
                    end else begin
                        hold_pend[d] = 1'b1;
                        hold_data[d] = bus.o_pe_data[d];
                    end
                end else if (hold_pend[d]) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL hold_valid port %0d: got 0 want 1", d);
                    hold_pend[d] = 1'b0;
                end
            end
            for (int s = 0; s < NUM_PE; s++) begin
                if (bus.i_pe_data_valid[s] && bus.o_pe_data_ready[s]) begin
                    e.f = tx_q[s][0];
                    e.acc_edge = cyc + 1;
                    dst = int'(flit_dest(e.f));
                    sb[s * NUM_PE + dst].push_back(e);
                    void'(tx_q[s].pop_front());
                    acc_count[s]++;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int s = 0; s < NUM_PE; s++) begin
            if (!rst && tx_q[s].size() > 0) begin
                bus.i_pe_data_valid[s] = 1'b1;
                bus.i_pe_data[s]       = tx_q[s][0];
            end else begin
                bus.i_pe_data_valid[s] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [NUM_PE-1:0] ored;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ored = '0;
        for (int p = 0; p < NUM_PE; p++) ored = ored | NUM_PE'(|bus.o_pe_data[p]);
        vectors++;
        if (valid_vec() !== '0) begin
            miscompares++;
            $display("FAIL reset_valid: got %h want 0000", valid_vec());
        end
        vectors++;
        if (ready_vec() !== '0) begin
            miscompares++;
            $display("FAIL reset_ready: got %h want 0000", ready_vec());
        end
        vectors++;
        if (ored !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got nonzero flags %h want 0", ored);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready_vec() !== '1) begin
            miscompares++;
            $display("FAIL release_ready: got %h want ffff", ready_vec());
        end
    endtask

    task automatic test_intra();
        int d0 = deliv_total;
        int p1 = del_count[1];
        tx_q[0].push_back(mk(1, 32'hDEADBEEF));
        for (int i = 0; i < 20 && del_count[1] == p1; i++) step();
        repeat (3) step();
        vectors++;
        if (del_count[1] - p1 !== 1) begin
            miscompares++;
            $display("FAIL intra_deliv: got %0d want 1", del_count[1] - p1);
        end
        vectors++;
        if (deliv_total - d0 !== 1) begin
            miscompares++;
            $display("FAIL intra_others_idle: got %0d deliveries want 1", deliv_total - d0);
        end
        vectors++;
        if (last_lat[1] !== 1) begin
            miscompares++;
            $display("FAIL intra_latency: got %0d want 1", last_lat[1]);
        end
    endtask

    task automatic test_inter();
        int p15 = del_count[15];
        tx_q[0].push_back(mk(15, 32'h12345678));
        for (int i = 0; i < 30 && del_count[15] == p15; i++) step();
        repeat (3) step();
        vectors++;
        if (del_count[15] - p15 !== 1) begin
            miscompares++;
            $display("FAIL inter_deliv: got %0d want 1", del_count[15] - p15);
        end
        vectors++;
        if (last_lat[15] !== 5) begin
            miscompares++;
            $display("FAIL inter_latency: got %0d want 5", last_lat[15]);
        end
    endtask

    task automatic test_round_robin();
        int p0 = del_count[0];
        deliv_src[0].delete();
        deliv_cyc[0].delete();
        for (int s = 1; s <= 3; s++) tx_q[s].push_back(mk(0, 32'hA000_0000 + s));
        for (int i = 0; i < 30 && del_count[0] - p0 < 3; i++) step();
        repeat (2) step();
        vectors++;
        if (deliv_src[0].size() !== 3) begin
            miscompares++;
            $display("FAIL rr_count: got %0d want 3", deliv_src[0].size());
        end
        if (deliv_src[0].size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (deliv_src[0][i] !== i + 1) begin
                    miscompares++;
                    $display("FAIL rr_order slot %0d: got src %0d want src %0d", i, deliv_src[0][i], i + 1);
                end
            end
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (deliv_cyc[0][i] - deliv_cyc[0][i-1] !== 1) begin
                    miscompares++;
                    $display("FAIL rr_back_to_back slot %0d: got gap %0d want 1", i, deliv_cyc[0][i] - deliv_cyc[0][i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int a0 = acc_count[4];
        int p5 = del_count[5];
        bus.i_pe_data_ready[5] = 1'b0;
        for (int i = 0; i < 4; i++) tx_q[4].push_back(mk(5, 32'h5000_0000 + i));
        repeat (10) step();
        vectors++;
        if (acc_count[4] - a0 !== 3) begin
            miscompares++;
            $display("FAIL bp_accepted: got %0d want 3", acc_count[4] - a0);
        end
        vectors++;
        if (bus.o_pe_data_ready[4] !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready4: got %b want 0", bus.o_pe_data_ready[4]);
        end
        vectors++;
        if (del_count[5] - p5 !== 0) begin
            miscompares++;
            $display("FAIL bp_held: got %0d deliveries want 0", del_count[5] - p5);
        end
        bus.i_pe_data_ready[5] = 1'b1;
        for (int i = 0; i < 30 && del_count[5] - p5 < 4; i++) step();
        repeat (2) step();
        vectors++;
        if (del_count[5] - p5 !== 4) begin
            miscompares++;
            $display("FAIL bp_release: got %0d deliveries want 4", del_count[5] - p5);
        end
    endtask

    task automatic test_random();
        int d0 = deliv_total;
        int base [NUM_PE];
        int left;
        int bad_ports;
        logic [31:0] r;
        for (int n = 0; n < NUM_PE; n++) begin
            base[n] = del_count[n];
            for (int i = 0; i < 100; i++) begin
                r = $urandom();
                tx_q[n].push_back(mk((n + 1) % NUM_PE, {4'(n), r[27:0]}));
            end
        end
        for (int i = 0; i < 3000 && deliv_total - d0 < 1600; i++) step();
        repeat (3) step();
        vectors++;
        if (deliv_total - d0 !== 1600) begin
            miscompares++;
            $display("FAIL rand_total: got %0d want 1600", deliv_total - d0);
        end
        left = 0;
        for (int k = 0; k < NUM_PE * NUM_PE; k++) left += sb[k].size();
        vectors++;
        if (left !== 0) begin
            miscompares++;
            $display("FAIL rand_leftover: got %0d pending want 0", left);
        end
        bad_ports = 0;
        for (int n = 0; n < NUM_PE; n++) if (del_count[n] - base[n] != 100) bad_ports++;
        vectors++;
        if (bad_ports !== 0) begin
            miscompares++;
            $display("FAIL rand_per_port: got %0d ports off want 0", bad_ports);
        end
`ifdef HNOC_PKT_COUNT_EN
        vectors++;
        if (pkt_count !== 32'(xfers)) begin
            miscompares++;
            $display("FAIL pkt_count: got %0d want %0d", pkt_count, xfers);
        end
`endif
    endtask

    task automatic test_reset_midflight();
        int d0;
        for (int n = 0; n < NUM_PE; n++) begin
            tx_q[n].push_back(mk((n + 5) % NUM_PE, 32'hC000_0000 + n));
            tx_q[n].push_back(mk((n + 5) % NUM_PE, 32'hC100_0000 + n));
        end
        repeat (3) step();
        rst = 1'b1;
        xfers = 0;
        for (int s = 0; s < NUM_PE; s++) begin
            tx_q[s].delete();
            bus.i_pe_data_valid[s] = 1'b0;
            hold_pend[s] = 1'b0;
        end
        for (int k = 0; k < NUM_PE * NUM_PE; k++) sb[k].delete();
        @(negedge clk);
        vectors++;
        if (valid_vec() !== '0) begin
            miscompares++;
            $display("FAIL midrst_valid: got %h want 0000", valid_vec());
        end
        vectors++;
        if (ready_vec() !== '0) begin
            miscompares++;
            $display("FAIL midrst_ready: got %h want 0000", ready_vec());
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready_vec() !== '1) begin
            miscompares++;
            $display("FAIL midrst_release_ready: got %h want ffff", ready_vec());
        end
        d0 = deliv_total;
        repeat (20) step();
        vectors++;
        if (deliv_total - d0 !== 0) begin
            miscompares++;
            $display("FAIL midrst_discard: got %0d deliveries want 0", deliv_total - d0);
        end
`ifdef HNOC_PKT_COUNT_EN
        vectors++;
        if (pkt_count !== 32'd0) begin
            miscompares++;
            $display("FAIL midrst_pkt_count: got %0d want 0", pkt_count);
        end
`endif
    endtask

    initial begin
        for (int p = 0; p < NUM_PE; p++) begin
            bus.i_pe_data[p]       = '0;
            bus.i_pe_data_valid[p] = 1'b0;
            bus.i_pe_data_ready[p] = 1'b1;
            del_count[p] = 0;
            acc_count[p] = 0;
            last_lat[p]  = -1;
            hold_pend[p] = 1'b0;
            hold_data[p] = '0;
        end
        test_reset();
        test_intra();
        test_inter();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end

endmodule
